// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the MIPS-subset main-control decoder.
//   - opcode values (IR[31:26]) of every instruction the decoder knows
//   - bit positions of each field inside the 13-bit control word
//   - encodings of the two multi-bit fields (destination reg, ALU B source)
package ctrl_pkg;

  localparam int unsigned SIG_W = 13;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Control-word bit indices (multi-bit fields give their lsb)
  localparam int unsigned SIG_JUMP   = 0;
  localparam int unsigned SIG_BRANCH = 1;
  localparam int unsigned SIG_JSRC   = 2;
  localparam int unsigned SIG_MEMW   = 3;
  localparam int unsigned SIG_MEMR   = 4;
  localparam int unsigned SIG_REGW   = 5;
  localparam int unsigned SIG_M2R    = 6;
  localparam int unsigned SIG_DST    = 7;
  localparam int unsigned SIG_BSRC   = 9;
  localparam int unsigned SIG_ASRC   = 11;
  localparam int unsigned SIG_RTYPE  = 12;

  // Destination register select; the value 3 is never produced.
  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2
  } dst_e;

  // ALU B operand select
  typedef enum logic [1:0] {
    BSRC_RB     = 2'd0,
    BSRC_FOUR   = 2'd1,
    BSRC_IMM    = 2'd2,
    BSRC_IMM_SH = 2'd3
  } bsrc_e;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode -> control word table.
// Ports:
//   op      in  [5:0]   instruction opcode
//   signal  out [12:0]  control word (all zero for unknown opcodes)
//   illegal out         1 when op is not in the table
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]       op,
  output logic [SIG_W-1:0] signal,
  output logic             illegal
);

  always_comb begin
    signal  = '0;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        signal[SIG_RTYPE]     = 1'b1;
        signal[SIG_ASRC]      = 1'b1;
        signal[SIG_DST +: 2]  = DST_RD;
        signal[SIG_BSRC +: 2] = BSRC_RB;
        signal[SIG_REGW]      = 1'b1;
      end
      OP_J: begin
        signal[SIG_JUMP] = 1'b1;
      end
      OP_JAL: begin
        // Link value: ALU computes PC + 4 with PC already advanced,
        // i.e. instruction address + 8.
        signal[SIG_JUMP]      = 1'b1;
        signal[SIG_REGW]      = 1'b1;
        signal[SIG_DST +: 2]  = DST_RA;
        signal[SIG_BSRC +: 2] = BSRC_FOUR;
      end
      OP_BEQ, OP_BNE: begin
        // Target = PC + (imm << 2); the CPU tells beq/bne apart from op.
        signal[SIG_BRANCH]    = 1'b1;
        signal[SIG_BSRC +: 2] = BSRC_IMM_SH;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        signal[SIG_ASRC]      = 1'b1;
        signal[SIG_BSRC +: 2] = BSRC_IMM;
        signal[SIG_DST +: 2]  = DST_RT;
        signal[SIG_REGW]      = 1'b1;
      end
      OP_LW: begin
        signal[SIG_ASRC]      = 1'b1;
        signal[SIG_BSRC +: 2] = BSRC_IMM;
        signal[SIG_DST +: 2]  = DST_RT;
        signal[SIG_M2R]       = 1'b1;
        signal[SIG_REGW]      = 1'b1;
        signal[SIG_MEMR]      = 1'b1;
      end
      OP_SW: begin
        signal[SIG_ASRC]      = 1'b1;
        signal[SIG_BSRC +: 2] = BSRC_IMM;
        signal[SIG_MEMW]      = 1'b1;
      end
      default: begin
        // Unknown opcode (incl. SLTI/SLTIU) decodes to a no-op.
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl.sv
// ctrl: main-control decoder with registered debug copy.
// Ports:
//   clk          in         rising-edge clock
//   rst          in         asynchronous active-low reset
//   op           in  [5:0]  opcode IR[31:26]
//   decode_en    in         qualifies op for the registered outputs
//   signal       out [12:0] combinational control word
//   illegal      out        combinational illegal-opcode flag
//   signal_q     out [12:0] registered copy of signal (loads when decode_en)
//   illegal_seen out        sticky illegal flag, cleared only by reset
module ctrl
  import ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             decode_en,
  output logic [SIG_W-1:0] signal,
  output logic             illegal,
  output logic [SIG_W-1:0] signal_q,
  output logic             illegal_seen
);

  logic [SIG_W-1:0] sig_q, sig_d;
  logic             seen_q, seen_d;

  ctrl_decode u_decode (
    .op      (op),
    .signal  (signal),
    .illegal (illegal)
  );

  // Hold path feeds back the register itself, so an unknown op while
  // decode_en is low never reaches the flops.
  always_comb begin
    sig_d  = sig_q;
    seen_d = seen_q;
    if (decode_en) begin
      sig_d  = signal;
      seen_d = seen_q | illegal;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      sig_q  <= sig_d;
      seen_q <= seen_d;
    end
  end

  assign signal_q     = sig_q;
  assign illegal_seen = seen_q;

endmodule

// File: tb/tb_ctrl.sv
module tb_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  op;
  logic        decode_en;
  logic [12:0] signal;
  logic        illegal;
  logic [12:0] signal_q;
  logic        illegal_seen;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [5:0]  op;
    logic [12:0] exp_sig;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[64];
  logic [13:0] exp_q[$];   // {illegal_seen, signal_q}

  ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .op           (op),
    .decode_en    (decode_en),
    .signal       (signal),
    .illegal      (illegal),
    .signal_q     (signal_q),
    .illegal_seen (illegal_seen)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (decode table) ----------------
  function automatic logic [13:0] model(input logic [5:0] o); // {illegal, signal}
    case (o)
      6'h00: return {1'b0, 13'h18A0};
      6'h02: return {1'b0, 13'h0001};
      6'h03: return {1'b0, 13'h0321};
      6'h04, 6'h05: return {1'b0, 13'h0602};
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return {1'b0, 13'h0C20};
      6'h23: return {1'b0, 13'h0C70};
      6'h2B: return {1'b0, 13'h0C08};
      default: return {1'b1, 13'h0000};
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // drive at negedge, then advance to just after the next rising edge
  task automatic step(input logic [5:0] o, input logic en);
    @(negedge clk);
    op = o;
    decode_en = en;
    @(posedge clk);
    #1;
  endtask

  logic [12:0] m_sig;
  logic        m_seen;
  logic [13:0] m;
  logic [13:0] got;
  int          n_ill;

  initial begin
    rst = 1'b0;
    op = 6'h03;
    decode_en = 1'b1;

    // reset held: registers stay zero across edges, comb path still works
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_signal_q", {3'b0, signal_q}, 16'h0000);
      check("rst_seen", {15'b0, illegal_seen}, 16'h0000);
      check("rst_comb_signal", {3'b0, signal}, 16'h0321);
    end

    // table sweep of every opcode
    for (int i = 0; i < 64; i++) begin
      m = model(6'(i));
      vecs[i].op = 6'(i);
      vecs[i].exp_sig = m[12:0];
      vecs[i].exp_ill = m[13];
    end
    n_ill = 0;
    for (int i = 0; i < 64; i++) begin
      op = vecs[i].op;
      #1;
      check($sformatf("sweep_sig_op%02h", vecs[i].op), {3'b0, signal}, {3'b0, vecs[i].exp_sig});
      check($sformatf("sweep_ill_op%02h", vecs[i].op), {15'b0, illegal}, {15'b0, vecs[i].exp_ill});
      if (illegal === 1'b1) n_ill++;
    end
    check("illegal_count", 16'(n_ill), 16'd51);

    // release reset, load then hold
    @(negedge clk);
    rst = 1'b1;
    step(6'h04, 1'b1);
    check("load_beq", {3'b0, signal_q}, 16'h0602);
    step(6'h23, 1'b0);
    check("hold_beq", {3'b0, signal_q}, 16'h0602);
    check("hold_comb_lw", {3'b0, signal}, 16'h0C70);

    // illegal op sets sticky flag, legal op keeps it
    @(negedge clk);
    op = 6'h0A;
    decode_en = 1'b1;
    #1;
    check("ill_comb_sig", {3'b0, signal}, 16'h0000);
    check("ill_comb_flag", {15'b0, illegal}, 16'h0001);
    @(posedge clk);
    #1;
    check("ill_seen_set", {15'b0, illegal_seen}, 16'h0001);
    check("ill_signal_q", {3'b0, signal_q}, 16'h0000);
    step(6'h08, 1'b1);
    check("ill_seen_sticky", {15'b0, illegal_seen}, 16'h0001);
    check("addi_signal_q", {3'b0, signal_q}, 16'h0C20);

    // asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    check("async_seen", {15'b0, illegal_seen}, 16'h0000);
    check("async_signal_q", {3'b0, signal_q}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // illegal op without decode_en does not set the flag
    @(negedge clk);
    op = 6'h3F;
    decode_en = 1'b0;
    #1;
    check("noen_ill_comb", {15'b0, illegal}, 16'h0001);
    @(posedge clk);
    #1;
    check("noen_seen", {15'b0, illegal_seen}, 16'h0000);

    // randomized run against the model, with occasional async resets
    m_sig = 13'h0;
    m_seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic [5:0] r_op;
      logic       r_en;
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        m_sig = 13'h0;
        m_seen = 1'b0;
      end
      // bias toward legal opcodes half the time
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 7))
          0: r_op = 6'h00;
          1: r_op = 6'h02;
          2: r_op = 6'h03;
          3: r_op = 6'h05;
          4: r_op = 6'h0D;
          5: r_op = 6'h23;
          6: r_op = 6'h2B;
          default: r_op = 6'h0F;
        endcase
      end else begin
        r_op = 6'($urandom_range(0, 63));
      end
      r_en = ($urandom_range(0, 3) != 0);
      op = r_op;
      decode_en = r_en;
      m = model(r_op);
      #1;
      check("rnd_comb", {2'b0, illegal, signal}, {2'b0, m});
      if (r_en) begin
        m_sig = m[12:0];
        m_seen = m_seen | m[13];
      end
      exp_q.push_back({m_seen, m_sig});
      @(posedge clk);
      #1;
      got = {illegal_seen, signal_q};
      if (exp_q.size() == 0) begin
        check("rnd_queue_empty", 16'h0001, 16'h0000);
      end else begin
        check("rnd_reg", {2'b0, got}, {2'b0, exp_q.pop_front()});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
